// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the fetch path: address / instruction widths, the
// fetch FSM state encoding and a small PC helper. Also used by the
// instruction memory and decode stage.
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;

    // Encoding is visible on the state output, so values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    // Sequential word address, wrapping modulo 256.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 8'd1;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Two-entry tagged instruction FIFO. Slot 0 is always the head, so the head
// outputs come straight from registers and stay stable under back-pressure.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_flush                 drop all entries (enqueue is suppressed upstream)
//   i_enq, i_enq_instr/pc   write one tagged instruction
//   i_ready                 consumer accepts the head when it is valid
//   o_instr, o_pc, o_valid  head entry
//   o_deq                   head handshake happens this cycle
//   o_count                 number of valid entries (0..2)
// -----------------------------------------------------------------------------
module fetch_buf
    import fetch_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_enq,
    input  logic [INSTR_W-1:0] i_enq_instr,
    input  logic [ADDR_W-1:0]  i_enq_pc,
    input  logic               i_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_valid,
    output logic               o_deq,
    output logic [1:0]         o_count
);

    logic [INSTR_W-1:0] r_instr0;
    logic [INSTR_W-1:0] r_instr1;
    logic [ADDR_W-1:0]  r_pc0;
    logic [ADDR_W-1:0]  r_pc1;
    logic [1:0]         r_count;

    logic               w_deq;
    logic [1:0]         w_count_after_deq;

    assign w_deq             = (r_count != 2'd0) && i_ready;
    assign w_count_after_deq = r_count - {1'b0, w_deq};

    // Entry storage and occupancy; a new entry lands in the first free slot
    // left after this cycle's dequeue has shifted slot 1 down.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr0 <= 32'h0000_0000;
            r_instr1 <= 32'h0000_0000;
            r_pc0    <= 8'h00;
            r_pc1    <= 8'h00;
            r_count  <= 2'd0;
        end else begin
            if (w_deq && (r_count == 2'd2)) begin
                r_instr0 <= r_instr1;
                r_pc0    <= r_pc1;
            end
            if (i_enq) begin
                if (w_count_after_deq == 2'd0) begin
                    r_instr0 <= i_enq_instr;
                    r_pc0    <= i_enq_pc;
                end else begin
                    r_instr1 <= i_enq_instr;
                    r_pc1    <= i_enq_pc;
                end
            end
            if (i_flush) begin
                r_count <= 2'd0;
            end else begin
                r_count <= w_count_after_deq + {1'b0, i_enq};
            end
        end
    end

    assign o_instr = r_instr0;
    assign o_pc    = r_pc0;
    assign o_valid = (r_count != 2'd0);
    assign o_deq   = w_deq;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch controller: FSM, next-PC and issue logic in front of a
// memory that returns data the cycle after the address is presented. Returned
// words are tagged with their address and queued in a 2-entry FIFO.
// Ports:
//   FETCH_CTRL_clk / _rst           clock, synchronous active-high reset
//   FETCH_CTRL_start                leave IDLE/HALTED, enter RUN
//   FETCH_CTRL_halt_req             stop issuing and drain
//   FETCH_CTRL_redir_valid / _pc    redirect strobe and target
//   FETCH_CTRL_imem_pc              registered memory address
//   FETCH_CTRL_imem_instr           memory read data
//   FETCH_CTRL_instr / _instr_pc    head instruction and its address tag
//   FETCH_CTRL_instr_valid / _ready head handshake
//   FETCH_CTRL_state                IDLE=0 RUN=1 DRAIN=2 HALTED=3
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC     = 8'h00,
    parameter bit                HALT_ON_WRAP = 1'b1
) (
    input  logic               FETCH_CTRL_clk,
    input  logic               FETCH_CTRL_rst,
    input  logic               FETCH_CTRL_start,
    input  logic               FETCH_CTRL_halt_req,
    input  logic               FETCH_CTRL_redir_valid,
    input  logic [ADDR_W-1:0]  FETCH_CTRL_redir_pc,
    output logic [ADDR_W-1:0]  FETCH_CTRL_imem_pc,
    input  logic [INSTR_W-1:0] FETCH_CTRL_imem_instr,
    output logic [INSTR_W-1:0] FETCH_CTRL_instr,
    output logic [ADDR_W-1:0]  FETCH_CTRL_instr_pc,
    output logic               FETCH_CTRL_instr_valid,
    input  logic               FETCH_CTRL_instr_ready,
    output logic [1:0]         FETCH_CTRL_state
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_next_pc;
    logic [ADDR_W-1:0] w_next_pc_nxt;
    logic [ADDR_W-1:0] r_imem_pc;
    logic              r_inflight;   // data for tag r_imem_pc is on the bus now

    logic              w_redir;
    logic              w_issue;
    logic              w_enq;
    logic              w_deq;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;

    // Redirects only matter while the fetch path is active.
    assign w_redir = FETCH_CTRL_redir_valid && ((r_state == ST_RUN) || (r_state == ST_DRAIN));

    // Occupancy counts the head leaving this cycle, so a steady stream keeps
    // one entry buffered plus one read in flight and still issues every cycle.
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_deq};
    assign w_issue = (r_state == ST_RUN) && !FETCH_CTRL_halt_req && !w_redir && (w_occ < 3'd2);

    // A redirect squashes whatever is returning in the strobe cycle.
    assign w_enq   = r_inflight && !w_redir;

    // Next-state and next-PC selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_next_pc_nxt = r_next_pc;
        case (r_state)
            ST_IDLE: begin
                if (FETCH_CTRL_start && !FETCH_CTRL_halt_req) begin
                    w_state_nxt   = ST_RUN;
                    w_next_pc_nxt = RESET_PC;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (FETCH_CTRL_halt_req) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_issue && HALT_ON_WRAP && (r_next_pc == 8'hFF)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!w_redir && (w_count == 2'd0) && !r_inflight) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                if (FETCH_CTRL_start && !FETCH_CTRL_halt_req) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HALTED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Redirect and issue never coincide (issue is blocked by a redirect).
        if (w_redir) begin
            w_next_pc_nxt = FETCH_CTRL_redir_pc;
        end else if (w_issue) begin
            w_next_pc_nxt = pc_inc(r_next_pc);
        end else begin
            w_next_pc_nxt = w_next_pc_nxt;
        end
    end

    // State, PC and in-flight tracking registers.
    always_ff @(posedge FETCH_CTRL_clk) begin
        if (FETCH_CTRL_rst) begin
            r_state    <= ST_IDLE;
            r_next_pc  <= RESET_PC;
            r_imem_pc  <= RESET_PC;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_next_pc  <= w_next_pc_nxt;
            if (w_issue) begin
                r_imem_pc <= r_next_pc;
            end
            r_inflight <= w_issue;
        end
    end

    fetch_buf u_buf (
        .i_clk       (FETCH_CTRL_clk),
        .i_rst       (FETCH_CTRL_rst),
        .i_flush     (w_redir),
        .i_enq       (w_enq),
        .i_enq_instr (FETCH_CTRL_imem_instr),
        .i_enq_pc    (r_imem_pc),
        .i_ready     (FETCH_CTRL_instr_ready),
        .o_instr     (FETCH_CTRL_instr),
        .o_pc        (FETCH_CTRL_instr_pc),
        .o_valid     (FETCH_CTRL_instr_valid),
        .o_deq       (w_deq),
        .o_count     (w_count)
    );

    assign FETCH_CTRL_imem_pc = r_imem_pc;
    assign FETCH_CTRL_state   = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, halt_req, redir_valid, ready;
    logic [7:0]  redir_pc;

    // default instance: RESET_PC=00, HALT_ON_WRAP=1
    logic [7:0]  imem_pc, instr_pc;
    logic [31:0] imem_instr, instr;
    logic        valid;
    logic [1:0]  state;

    // wrapping instance: RESET_PC=10, HALT_ON_WRAP=0
    logic [7:0]  w_imem_pc, w_instr_pc;
    logic [31:0] w_imem_instr, w_instr;
    logic        w_valid;
    logic [1:0]  w_state;

    int          total = 0;
    int          bad   = 0;

    logic        acc, accw;
    logic [7:0]  acc_pc, accw_pc;
    logic [31:0] acc_instr;
    logic [7:0]  exp_tag;

    // reference memory content: word k holds A000_0000 + k
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return 32'hA000_0000 + {24'h000000, a};
    endfunction

    assign imem_instr   = mem_word(imem_pc);
    assign w_imem_instr = mem_word(w_imem_pc);

    fetch_ctrl dut (
        .FETCH_CTRL_clk(clk), .FETCH_CTRL_rst(rst), .FETCH_CTRL_start(start),
        .FETCH_CTRL_halt_req(halt_req), .FETCH_CTRL_redir_valid(redir_valid),
        .FETCH_CTRL_redir_pc(redir_pc), .FETCH_CTRL_imem_pc(imem_pc),
        .FETCH_CTRL_imem_instr(imem_instr), .FETCH_CTRL_instr(instr),
        .FETCH_CTRL_instr_pc(instr_pc), .FETCH_CTRL_instr_valid(valid),
        .FETCH_CTRL_instr_ready(ready), .FETCH_CTRL_state(state)
    );

    fetch_ctrl #(.RESET_PC(8'h10), .HALT_ON_WRAP(1'b0)) dut_w (
        .FETCH_CTRL_clk(clk), .FETCH_CTRL_rst(rst), .FETCH_CTRL_start(start),
        .FETCH_CTRL_halt_req(halt_req), .FETCH_CTRL_redir_valid(redir_valid),
        .FETCH_CTRL_redir_pc(redir_pc), .FETCH_CTRL_imem_pc(w_imem_pc),
        .FETCH_CTRL_imem_instr(w_imem_instr), .FETCH_CTRL_instr(w_instr),
        .FETCH_CTRL_instr_pc(w_instr_pc), .FETCH_CTRL_instr_valid(w_valid),
        .FETCH_CTRL_instr_ready(ready), .FETCH_CTRL_state(w_state)
    );

    // One clock cycle. Called at a negedge; drives inputs, records whether the
    // head is accepted at the coming posedge, returns at the following negedge.
    task automatic tick(input logic rdy, input logic st, input logic hr,
                        input logic rv, input logic [7:0] rpc);
        ready = rdy; start = st; halt_req = hr; redir_valid = rv; redir_pc = rpc;
        acc = valid && rdy;     acc_pc  = instr_pc; acc_instr = instr;
        accw = w_valid && rdy;  accw_pc = w_instr_pc;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; redir_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        total++; if (instr_pc !== 8'h00) begin bad++; $display("FAIL reset_instr_pc: got %h want 00", instr_pc); end
        total++; if (imem_pc !== 8'h00) begin bad++; $display("FAIL reset_imem_pc: got %h want 00", imem_pc); end
        total++; if (w_imem_pc !== 8'h10) begin bad++; $display("FAIL reset_imem_pc_w: got %h want 10", w_imem_pc); end
    endtask

    task automatic test_startup();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);   // start sampled at edge E
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL start_e0: valid got %0b want 0", valid); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL start_e1: valid got %0b want 0", valid); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (valid !== 1'b1 || instr_pc !== 8'h00)
            begin bad++; $display("FAIL start_e2: valid=%0b pc=%h want 1/00", valid, instr_pc); end
        total++; if (w_valid !== 1'b1 || w_instr_pc !== 8'h10)
            begin bad++; $display("FAIL start_e2_w: valid=%0b pc=%h want 1/10", w_valid, w_instr_pc); end
        exp_tag = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            total++;
            if (!acc || acc_pc !== exp_tag || acc_instr !== mem_word(exp_tag)) begin
                bad++; $display("FAIL stream: acc=%0b pc=%h data=%h want pc=%h data=%h",
                                acc, acc_pc, acc_instr, exp_tag, mem_word(exp_tag));
            end
            exp_tag = exp_tag + 8'd1;
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            total++;
            if (acc || !valid || instr_pc !== exp_tag || instr !== mem_word(exp_tag) ||
                imem_pc !== exp_tag + 8'd1) begin
                bad++; $display("FAIL stall: acc=%0b valid=%0b head=%h imem_pc=%h want head=%h imem_pc=%h",
                                acc, valid, instr_pc, imem_pc, exp_tag, exp_tag + 8'd1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            total++;
            if (!acc || acc_pc !== exp_tag) begin
                bad++; $display("FAIL resume: acc=%0b pc=%h want %h", acc, acc_pc, exp_tag);
            end
            exp_tag = exp_tag + 8'd1;
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        n = 0;
        while (!(valid && instr_pc == 8'h05) && n < 20) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        total++; if (n >= 20) begin bad++; $display("FAIL redir_reach5: head %h want 05", instr_pc); end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h40);
        total++; if (!acc || acc_pc !== 8'h05) begin bad++; $display("FAIL redir_accept5: acc=%0b pc=%h want 05", acc, acc_pc); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL redir_flush: valid got %0b want 0", valid); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL redir_s1: valid got %0b want 0 (pc %h)", valid, instr_pc); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (valid !== 1'b1 || instr_pc !== 8'h40)
            begin bad++; $display("FAIL redir_s2: valid=%0b pc=%h want 1/40", valid, instr_pc); end
        exp_tag = 8'h40;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            total++; if (!acc || acc_pc !== exp_tag) begin bad++; $display("FAIL redir_seq: pc=%h want %h", acc_pc, exp_tag); end
            exp_tag = exp_tag + 8'd1;
        end
    endtask

    task automatic test_halt();
        int n;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        exp_tag = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            exp_tag = exp_tag + 8'd1;
        end
        n = 0;
        while (state != 2'd3 && n < 20) begin
            tick($urandom_range(0, 1) != 0, 1'b0, 1'b1, 1'b0, 8'h00);
            if (acc) begin
                total++; if (acc_pc !== exp_tag) begin bad++; $display("FAIL drain_seq: pc=%h want %h", acc_pc, exp_tag); end
                exp_tag = exp_tag + 8'd1;
            end
            n++;
        end
        total++; if (state !== 2'd3) begin bad++; $display("FAIL halt_reach: state %0d want 3", state); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL halt_valid: got %0b want 0", valid); end
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);   // halt wins over start
        total++; if (state !== 2'd3) begin bad++; $display("FAIL halt_prio: state %0d want 3", state); end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 8) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        total++; if (!acc || acc_pc !== exp_tag) begin bad++; $display("FAIL halt_resume: acc=%0b pc=%h want %h", acc, acc_pc, exp_tag); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] qw[$];
        logic [7:0] e;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 8'hFD);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (acc)  q.push_back(acc_pc);
            if (accw) qw.push_back(accw_pc);
        end
        total++; if (q.size() != 3) begin bad++; $display("FAIL wrap_count: got %0d want 3", q.size()); end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            e = 8'hFD + 8'(i);
            total++; if (q[i] !== e) begin bad++; $display("FAIL wrap_tag: got %h want %h", q[i], e); end
        end
        total++; if (state !== 2'd3 || valid !== 1'b0)
            begin bad++; $display("FAIL wrap_halted: state=%0d valid=%0b want 3/0", state, valid); end
        total++; if (qw.size() < 6) begin bad++; $display("FAIL wrapw_count: got %0d want >=6", qw.size()); end
        for (int i = 0; i < 6 && i < qw.size(); i++) begin
            e = 8'hFD + 8'(i);
            total++; if (qw[i] !== e) begin bad++; $display("FAIL wrapw_tag: got %h want %h", qw[i], e); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        total++; if (state !== 2'd0 || valid !== 1'b0 || imem_pc !== 8'h00 || instr_pc !== 8'h00)
            begin bad++; $display("FAIL midreset: state=%0d valid=%0b imem_pc=%h pc=%h want 0/0/00/00",
                                  state, valid, imem_pc, instr_pc); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            total++; if (acc || valid !== 1'b0) begin bad++; $display("FAIL midreset_stale: acc=%0b valid=%0b want 0/0", acc, valid); end
        end
    endtask

    task automatic test_random();
        int         n_acc;
        logic       rdy, rv;
        logic [7:0] tgt;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        exp_tag = 8'h00;
        n_acc   = 0;
        for (int i = 0; i < 400; i++) begin
            if (valid) begin
                total++;
                if (instr_pc !== exp_tag || instr !== mem_word(exp_tag)) begin
                    bad++; $display("FAIL rand_head: pc=%h data=%h want pc=%h data=%h",
                                    instr_pc, instr, exp_tag, mem_word(exp_tag));
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            rv  = (state == 2'd1) && (($urandom_range(0, 15) == 0) || (exp_tag > 8'hC0));
            tgt = 8'($urandom_range(0, 127));
            tick(rdy, 1'b0, 1'b0, rv, tgt);
            if (acc) begin
                exp_tag = exp_tag + 8'd1;
                n_acc++;
            end
            if (rv) exp_tag = tgt;
        end
        total++; if (n_acc < 150) begin bad++; $display("FAIL rand_throughput: accepted %0d want >=150", n_acc); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; redir_valid = 1'b0;
        ready = 1'b0; redir_pc = 8'h00;
        @(negedge clk);
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
